multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 222 ++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle RV32-style control FSM: sequences fetch/decode/execute/memory/
// writeback and drives datapath selects and register write enables.
// Outputs are decoded combinationally from the current state (plus
// mem_ready / branch_taken where noted). The debug state code follows
// the state listing order: FETCH=0 ... HALT=13, ERROR=14.
// Optional feature macro: ECALL_HALT_EN (ecall halts the controller
// until reset). When the macro is undefined, ecall executes as a NOP.
module multicycle_controller #(
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [2:0] ALUControl,
    output logic [3:0] state,
    output logic       err
);

    localparam int unsigned CNT_W = $clog2(WAIT_LIMIT + 1);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_UPPER    = 4'd12,
        S_HALT     = 4'd13,
        S_ERROR    = 4'd14
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             jalr_q, jalr_d;
    logic             timeout;

    // This cycle is the WAIT_LIMIT-th consecutive not-ready cycle of an access
    assign timeout = (cnt_q == CNT_W'(WAIT_LIMIT - 1)) && !mem_ready;
    assign state   = state_q;

    // State, wait counter and JALR phase registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            jalr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            jalr_q  <= jalr_d;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        jalr_d     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = 3'b000;
        err        = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                // Request is withdrawn in the cycle the access is abandoned
                mem_req   = !timeout;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_ERROR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI, OP_AUIPC:  state_d = S_UPPER;
`ifdef ECALL_HALT_EN
                    OP_SYSTEM:         state_d = S_HALT;
`else
                    OP_SYSTEM:         state_d = S_FETCH;
`endif
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_req = !timeout;
                AdrSrc  = 1'b1;
                if (mem_ready)    state_d = S_MEMWB;
                else if (timeout) state_d = S_ERROR;
                else              cnt_d   = cnt_q + CNT_W'(1);
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                // Write qualifier has no meaning once the request is dropped
                mem_req = !timeout;
                mem_we  = !timeout;
                AdrSrc  = 1'b1;
                if (mem_ready)    state_d = S_FETCH;
                else if (timeout) state_d = S_ERROR;
                else              cnt_d   = cnt_q + CNT_W'(1);
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = funct3;
                state_d    = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = funct3;
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA = 2'b10;
                PCWrite = branch_taken;
                case (funct3[2:1])
                    2'b10:   ALUControl = 3'b010;
                    2'b11:   ALUControl = 3'b011;
                    default: ALUControl = 3'b000;
                endcase
                state_d = S_FETCH;
            end
            S_JAL: begin
                PCWrite = 1'b1;
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                state_d = S_ALUWB;
            end
            S_JALR: begin
                // First cycle redirects PC to rs1+imm, second captures OldPC+4
                if (!jalr_q) begin
                    ALUSrcA   = 2'b10;
                    ALUSrcB   = 2'b01;
                    ResultSrc = 2'b10;
                    PCWrite   = 1'b1;
                    jalr_d    = 1'b1;
                end else begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b10;
                    state_d = S_ALUWB;
                end
            end
            S_UPPER: begin
                ALUSrcB = 2'b01;
                if (opcode == OP_LUI) begin
                    ALUSrcA    = 2'b00;
                    ALUControl = 3'b111;
                end else begin
                    ALUSrcA = 2'b01;
                end
                state_d = S_ALUWB;
            end
            S_HALT:  state_d = S_HALT;
            S_ERROR: err     = 1'b1;
            default: state_d = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: each instruction is expanded
// into a queue of expected per-cycle records (inputs to drive plus required
// state/outputs), then replayed against the DUT one cycle at a time.
module tb_multicycle_controller;

    localparam int WL          = 15;
    localparam int HALT_CYCLES = 100;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [3:0] ST_FETCH = 4'd0,  ST_DECODE = 4'd1,  ST_MEMADR = 4'd2,
                           ST_MEMREAD = 4'd3, ST_MEMWB = 4'd4,  ST_MEMWRITE = 4'd5,
                           ST_EXECR = 4'd6,  ST_EXECI = 4'd7,   ST_ALUWB = 4'd8,
                           ST_BRANCH = 4'd9, ST_JAL = 4'd10,    ST_JALR = 4'd11,
                           ST_UPPER = 4'd12, ST_HALT = 4'd13,   ST_ERROR = 4'd14;

    // outs = {req, we, adr, irw, pcw, rw, srcA[2], srcB[2], res[2], alu[3], err}
    typedef struct packed {
        logic [3:0]  st;
        logic        rdy;
        logic        bt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [15:0] outs;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       branch_taken;
    logic       mem_ready;
    logic       mem_req, mem_we, AdrSrc, IRWrite, PCWrite, RegWrite, err;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [2:0] ALUControl;
    logic [3:0] state;
    logic [15:0] dut_outs;

    rec_t       exp_q[$];
    logic [6:0] cur_op;
    logic [2:0] cur_f3;
    int         n_checks = 0;
    int         n_fail   = 0;

    multicycle_controller #(.WAIT_LIMIT(WL)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .AdrSrc(AdrSrc),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ALUControl(ALUControl), .state(state), .err(err)
    );

    assign dut_outs = {mem_req, mem_we, AdrSrc, IRWrite, PCWrite, RegWrite,
                       ALUSrcA, ALUSrcB, ResultSrc, ALUControl, err};

    always #5 clk = ~clk;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [15:0] o(input logic req, input logic we, input logic adr,
                                      input logic irw, input logic pcw, input logic rw,
                                      input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] rs, input logic [2:0] alu,
                                      input logic e);
        return {req, we, adr, irw, pcw, rw, a, b, rs, alu, e};
    endfunction

    function automatic logic [2:0] br_alu(input logic [2:0] f3);
        if (f3[2] && f3[1]) return 3'b011;
        if (f3[2])          return 3'b010;
        return 3'b000;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, got, want, $time);
        end
    endtask

    task automatic push(input logic [3:0] st, input logic rdy, input logic bt, input logic [15:0] outs);
        rec_t r;
        r.st = st; r.rdy = rdy; r.bt = bt; r.op = cur_op; r.f3 = cur_f3; r.outs = outs;
        exp_q.push_back(r);
    endtask

    // A memory wait phase: waits cycles with mem_ready low, then completion
    task automatic gen_access(input logic [3:0] st, input logic we, input logic adr,
                              input logic [1:0] b, input logic [1:0] rs, input int waits);
        for (int i = 0; i < waits; i++) push(st, 1'b0, rb(), o(1, we, adr, 0, 0, 0, 2'b00, b, rs, 3'b000, 0));
        if (st == ST_FETCH) push(st, 1'b1, rb(), o(1, 0, 0, 1, 1, 0, 2'b00, b, rs, 3'b000, 0));
        else                push(st, 1'b1, rb(), o(1, we, adr, 0, 0, 0, 2'b00, b, rs, 3'b000, 0));
    endtask

    // Access never completes: request dropped on the limit cycle, then ERROR
    task automatic gen_timeout(input logic [3:0] st, input logic we, input logic adr,
                               input logic [1:0] b, input logic [1:0] rs);
        for (int i = 0; i < WL - 1; i++) push(st, 1'b0, rb(), o(1, we, adr, 0, 0, 0, 2'b00, b, rs, 3'b000, 0));
        push(st, 1'b0, rb(), o(0, 0, adr, 0, 0, 0, 2'b00, b, rs, 3'b000, 0));
        for (int i = 0; i < 6; i++) push(ST_ERROR, rb(), rb(), o(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1));
    endtask

    task automatic push_aluwb();
        push(ST_ALUWB, rb(), rb(), o(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 0));
    endtask

    task automatic gen_instr(input logic [6:0] op, input logic [2:0] f3, input logic bt,
                             input int fw, input int mw);
        cur_op = op; cur_f3 = f3;
        gen_access(ST_FETCH, 1'b0, 1'b0, 2'b10, 2'b10, fw);
        push(ST_DECODE, rb(), rb(), o(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b000, 0));
        case (op)
            OP_LOAD: begin
                push(ST_MEMADR, rb(), rb(), o(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000, 0));
                gen_access(ST_MEMREAD, 1'b0, 1'b1, 2'b00, 2'b00, mw);
                push(ST_MEMWB, rb(), rb(), o(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, 3'b000, 0));
            end
            OP_STORE: begin
                push(ST_MEMADR, rb(), rb(), o(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000, 0));
                gen_access(ST_MEMWRITE, 1'b1, 1'b1, 2'b00, 2'b00, mw);
            end
            OP_RTYPE: begin
                push(ST_EXECR, rb(), rb(), o(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, f3, 0));
                push_aluwb();
            end
            OP_ITYPE: begin
                push(ST_EXECI, rb(), rb(), o(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, f3, 0));
                push_aluwb();
            end
            OP_BRANCH:
                push(ST_BRANCH, rb(), bt, o(0, 0, 0, 0, bt, 0, 2'b10, 2'b00, 2'b00, br_alu(f3), 0));
            OP_JAL: begin
                push(ST_JAL, rb(), rb(), o(0, 0, 0, 0, 1, 0, 2'b01, 2'b10, 2'b00, 3'b000, 0));
                push_aluwb();
            end
            OP_JALR: begin
                push(ST_JALR, rb(), rb(), o(0, 0, 0, 0, 1, 0, 2'b10, 2'b01, 2'b10, 3'b000, 0));
                push(ST_JALR, rb(), rb(), o(0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 3'b000, 0));
                push_aluwb();
            end
            OP_LUI: begin
                push(ST_UPPER, rb(), rb(), o(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 3'b111, 0));
                push_aluwb();
            end
            OP_AUIPC: begin
                push(ST_UPPER, rb(), rb(), o(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b000, 0));
                push_aluwb();
            end
            OP_SYSTEM: begin
`ifdef ECALL_HALT_EN
                for (int i = 0; i < HALT_CYCLES; i++)
                    push(ST_HALT, rb(), rb(), o(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0));
`endif
            end
            default: ;
        endcase
    endtask

    // Replay queued cycles; caller sits at a falling edge. Optionally stop
    // right after checking the first record in stop_st (mid low phase).
    task automatic play(input int stop_st);
        rec_t r;
        while (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            opcode = r.op; funct3 = r.f3; mem_ready = r.rdy; branch_taken = r.bt;
            #1;
            check($sformatf("cycle st=%0d op=%b", r.st, r.op), 32'({state, dut_outs}), 32'({r.st, r.outs}));
            if (int'(r.st) == stop_st) begin
                exp_q.delete();
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("reset_state", 32'(state), 32'(ST_FETCH));
        check("reset_err", 32'(err), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [6:0] rand_op();
        logic [6:0] ops [10];
        logic [6:0] x;
        ops = '{OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL,
                OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM};
        if ($urandom_range(0, 10) != 0) begin
            x = ops[$urandom_range(0, 9)];
`ifdef ECALL_HALT_EN
            if (x == OP_SYSTEM) x = OP_ITYPE;
`endif
            return x;
        end
        for (int k = 0; k < 50; k++) begin
            x = 7'($urandom);
            if (!(x inside {OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL,
                            OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM})) return x;
        end
        return 7'b0000000;
    endfunction

    function automatic int rand_wait();
        if ($urandom_range(0, 9) == 0) return WL - 1;
        return int'($urandom_range(0, 3));
    endfunction

    // Guard against a stuck run
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst_n = 1'b0; opcode = '0; funct3 = '0; branch_taken = 1'b0; mem_ready = 1'b0;
        cur_op = '0; cur_f3 = '0;
        #2;
        check("reset_state", 32'(state), 32'(ST_FETCH));
        check("reset_err", 32'(err), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // addi x1,x0,5: four cycles, one RegWrite
        gen_instr(OP_ITYPE, 3'b000, 1'b0, 0, 0);
        check("addi_len", 32'(exp_q.size()), 32'd4);
        cnt = 0;
        foreach (exp_q[i]) if (exp_q[i].outs[10]) cnt++;
        check("addi_regwrite_cycles", 32'(cnt), 32'd1);
        play(-1);

        // lw with three not-ready cycles in MEMREAD: eight cycles
        gen_instr(OP_LOAD, 3'b010, 1'b0, 0, 3);
        check("lw_len", 32'(exp_q.size()), 32'd8);
        cnt = 0;
        foreach (exp_q[i]) if (exp_q[i].st == ST_MEMREAD && exp_q[i].outs[15]) cnt++;
        check("lw_req_cycles", 32'(cnt), 32'd4);
        play(-1);

        // beq not taken then taken
        gen_instr(OP_BRANCH, 3'b000, 1'b0, 0, 0);
        gen_instr(OP_BRANCH, 3'b000, 1'b1, 0, 0);
        check("beq_pcw0", 32'(exp_q[2].outs[11]), 32'd0);
        check("beq_pcw1", 32'(exp_q[5].outs[11]), 32'd1);
        play(-1);

        // mem_ready on the last allowed cycle completes normally
        gen_instr(OP_LOAD, 3'b000, 1'b0, WL - 1, WL - 1);
        gen_instr(OP_STORE, 3'b000, 1'b0, 0, WL - 1);
        play(-1);

        // ecall
        gen_instr(OP_SYSTEM, 3'b000, 1'b0, 0, 0);
        play(-1);
`ifdef ECALL_HALT_EN
        do_reset();
`endif

        // Randomized instruction stream
        for (int n = 0; n < 300; n++)
            gen_instr(rand_op(), 3'($urandom), rb(), rand_wait(), rand_wait());
        play(-1);

        // Fetch timeout, then recovery by reset
        cur_op = OP_ITYPE; cur_f3 = 3'b000;
        gen_timeout(ST_FETCH, 1'b0, 1'b0, 2'b10, 2'b10);
        play(-1);
        do_reset();
        gen_instr(OP_ITYPE, 3'b001, 1'b0, 1, 0);
        play(-1);

        // Store timeout
        gen_instr(OP_STORE, 3'b010, 1'b0, 0, 0);
        void'(exp_q.pop_back());
        gen_timeout(ST_MEMWRITE, 1'b1, 1'b1, 2'b00, 2'b00);
        play(-1);
        do_reset();

        // Asynchronous reset in the middle of a store
        gen_instr(OP_STORE, 3'b010, 1'b0, 0, 5);
        play(int'(ST_MEMWRITE));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_state", 32'(state), 32'(ST_FETCH));
        check("async_mem_we", 32'(mem_we), 32'd0);
        check("async_err", 32'(err), 32'd0);
        @(negedge clk);
        do_reset();
        gen_instr(OP_JALR, 3'b000, 1'b0, 0, 0);
        play(-1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
